// File: rtl/i2c_slave_regmap.sv
// EEPROM-style register file behind the I2C slave core's user interface.
// First write byte loads the pointer; later bytes write/read registers with auto-increment.
module i2c_slave_regmap #(
  parameter int                NREG    = 16,
  parameter int                ADDR_W  = 4,
  parameter logic [NREG-1:0]   RO_MASK = {NREG{1'b0}},
  parameter logic [8*NREG-1:0] RST_VAL = {NREG{8'h00}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          status_i,
  input  logic [7:0]          rx_data_i,
  output logic [7:0]          data_in_o,
  output logic                tx_data_en_o,
  input  logic                hw_we_i,
  input  logic [ADDR_W-1:0]   hw_addr_i,
  input  logic [7:0]          hw_wdata_i,
  output logic [8*NREG-1:0]   regs_o,
  output logic                i2c_wr_o,
  output logic [ADDR_W-1:0]   i2c_wr_addr_o,
  output logic [ADDR_W-1:0]   ptr_o,
  output logic                busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_WR    = 2'd2;
  localparam logic [1:0] S_RD    = 2'd3;

  logic [1:0]        r_state;
  logic              r_tx_prev;
  logic              r_rx_prev;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_regs [NREG];
  logic [7:0]        r_data_in;
  logic              r_tx_en;
  logic              r_wr;
  logic [ADDR_W-1:0] r_wr_addr;

  logic              w_sta, w_sto, w_tx_rise, w_rx_rise, w_ev;
  logic              w_set_ptr, w_do_wr, w_do_rd, w_wr_ok;
  logic              w_ptr_hit, w_ptr_ro;
  logic [7:0]        w_ptr_rdata;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [1:0]        w_next_state;
  logic              w_unused;

  assign w_sta     = status_i[0];
  assign w_sto     = status_i[1];
  assign w_tx_rise = status_i[2] & ~r_tx_prev;
  assign w_rx_rise = status_i[3] & ~r_rx_prev;
  assign w_unused  = ^status_i[7:4];

  // Start/stop pulses take the cycle; a data edge coinciding with them is not acted on.
  assign w_ev      = ~w_sta & ~w_sto;
  assign w_set_ptr = w_ev & w_rx_rise & (r_state == S_FIRST);
  assign w_do_wr   = w_ev & w_rx_rise & (r_state == S_WR);
  assign w_do_rd   = w_ev & w_tx_rise & ((r_state == S_RD) |
                     (((r_state == S_FIRST) | (r_state == S_WR)) & ~w_rx_rise));
  assign w_wr_ok   = w_do_wr & w_ptr_hit & ~w_ptr_ro;

  assign w_ptr_inc = (int'(r_ptr) >= NREG - 1) ? '0 : r_ptr + ADDR_W'(1);

  always_comb begin
    w_ptr_hit   = 1'b0;
    w_ptr_ro    = 1'b0;
    w_ptr_rdata = 8'hFF;
    for (int i = 0; i < NREG; i++) begin
      if (r_ptr == ADDR_W'(i)) begin
        w_ptr_hit   = 1'b1;
        w_ptr_ro    = RO_MASK[i];
        w_ptr_rdata = r_regs[i];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_sta) begin
      w_next_state = S_FIRST;
    end else if (w_sto) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_FIRST: begin
          if (w_rx_rise)      w_next_state = S_WR;
          else if (w_tx_rise) w_next_state = S_RD;
        end
        S_WR: begin
          if (!w_rx_rise && w_tx_rise) w_next_state = S_RD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tx_prev <= 1'b0;
      r_rx_prev <= 1'b0;
      r_ptr     <= '0;
      r_data_in <= 8'hFF;
      r_tx_en   <= 1'b0;
      r_wr      <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_state   <= w_next_state;
      r_tx_prev <= status_i[2];
      r_rx_prev <= status_i[3];
      r_tx_en   <= w_do_rd;
      r_wr      <= w_wr_ok;
      if (w_wr_ok) r_wr_addr <= r_ptr;
      // Read value is the pre-write register content, out-of-range reads return FF.
      if (w_do_rd) r_data_in <= w_ptr_rdata;
      if (w_set_ptr)               r_ptr <= rx_data_i[ADDR_W-1:0];
      else if (w_do_wr || w_do_rd) r_ptr <= w_ptr_inc;
    end
  end

  // Local write is applied last so it wins a same-register collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= RST_VAL[8*i +: 8];
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr_ok && r_ptr == ADDR_W'(i))      r_regs[i] <= rx_data_i;
        if (hw_we_i && hw_addr_i == ADDR_W'(i))  r_regs[i] <= hw_wdata_i;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs_out
    assign regs_o[8*g +: 8] = r_regs[g];
  end

  assign data_in_o     = r_data_in;
  assign tx_data_en_o  = r_tx_en;
  assign i2c_wr_o      = r_wr;
  assign i2c_wr_addr_o = r_wr_addr;
  assign ptr_o         = r_ptr;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Bench for i2c_slave_regmap: directed transfers plus random traffic against a
// register-array model; a negedge monitor pops expected tx bytes and write addresses.
module tb_i2c_slave_regmap;

  localparam int NREG   = 12;
  localparam int ADDR_W = 4;
  localparam logic [NREG-1:0] RO_MASK = 12'h004;

  function automatic logic [8*NREG-1:0] mk_rst();
    logic [8*NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = 8'(8'h30 + 7 * i);
    return v;
  endfunction
  localparam logic [8*NREG-1:0] RST_VAL = mk_rst();

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [7:0]          status = 8'h00;
  logic [7:0]          rx_data = 8'h00;
  logic                hw_we = 1'b0;
  logic [ADDR_W-1:0]   hw_addr = '0;
  logic [7:0]          hw_wdata = 8'h00;
  logic [7:0]          data_in_o;
  logic                tx_data_en_o;
  logic [8*NREG-1:0]   regs_o;
  logic                i2c_wr_o;
  logic [ADDR_W-1:0]   i2c_wr_addr_o;
  logic [ADDR_W-1:0]   ptr_o;
  logic                busy_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]        exp_tx_q[$];
  logic [ADDR_W-1:0] exp_wr_q[$];

  // Reference model: register array, pointer, transfer phase
  // (0 idle, 1 awaiting pointer byte, 2 writing data, 3 reading).
  logic [7:0] m_regs [NREG];
  int         m_ptr;
  int         m_mode;

  i2c_slave_regmap #(
    .NREG(NREG), .ADDR_W(ADDR_W), .RO_MASK(RO_MASK), .RST_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .status_i(status), .rx_data_i(rx_data),
    .data_in_o(data_in_o), .tx_data_en_o(tx_data_en_o),
    .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_wdata_i(hw_wdata),
    .regs_o(regs_o), .i2c_wr_o(i2c_wr_o), .i2c_wr_addr_o(i2c_wr_addr_o),
    .ptr_o(ptr_o), .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_next(int p);
    return (p >= NREG - 1) ? 0 : p + 1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = RST_VAL[8*i +: 8];
    m_ptr  = 0;
    m_mode = 0;
  endtask

  task automatic chk_regs(input string name);
    logic [8*NREG-1:0] e;
    for (int i = 0; i < NREG; i++) e[8*i +: 8] = m_regs[i];
    chk(name, regs_o, e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (tx_data_en_o) begin
        if (exp_tx_q.size() == 0) chk("tx_unexpected", tx_data_en_o, 0);
        else chk("tx_data", data_in_o, exp_tx_q.pop_front());
      end
      if (i2c_wr_o) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", i2c_wr_o, 0);
        else chk("wr_addr", i2c_wr_addr_o, exp_wr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic junk();
    status[7:5] = 3'($urandom);
  endtask

  task automatic drv_sta();
    junk();
    status[0] = 1'b1;
    m_mode = 1;
    @(negedge clk);
    status[0] = 1'b0;
    chk("busy_after_sta", busy_o, 1);
  endtask

  task automatic drv_sto();
    junk();
    status[1] = 1'b1;
    m_mode = 0;
    @(negedge clk);
    status[1] = 1'b0;
    chk("busy_after_sto", busy_o, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit collide, input logic [7:0] hv);
    junk();
    status[4] = 1'b0;
    rx_data = b;
    status[3] = 1'b1;
    if (collide) begin
      hw_we = 1'b1;
      hw_addr = ADDR_W'(m_ptr);
      hw_wdata = hv;
    end
    if (m_mode == 1) begin
      m_ptr  = int'(b[ADDR_W-1:0]);
      m_mode = 2;
    end else if (m_mode == 2) begin
      if (m_ptr < NREG && !RO_MASK[m_ptr]) begin
        m_regs[m_ptr] = b;
        exp_wr_q.push_back(ADDR_W'(m_ptr));
      end
      if (collide && m_ptr < NREG) m_regs[m_ptr] = hv;
      m_ptr = m_next(m_ptr);
    end else if (collide && m_ptr < NREG) begin
      m_regs[m_ptr] = hv;
    end
    @(negedge clk);
    status[3] = 1'b0;
    hw_we = 1'b0;
    chk("ptr_after_rx", ptr_o, m_ptr);
    chk_regs("regs_after_rx");
    @(negedge clk);
  endtask

  task automatic read_tx();
    bit exp_en;
    junk();
    status[4] = 1'b1;
    status[2] = 1'b1;
    exp_en = (m_mode != 0);
    if (exp_en) begin
      exp_tx_q.push_back((m_ptr < NREG) ? m_regs[m_ptr] : 8'hFF);
      m_ptr  = m_next(m_ptr);
      m_mode = 3;
    end
    @(negedge clk);
    chk("tx_en_latency", tx_data_en_o, exp_en);
    chk("ptr_after_tx", ptr_o, m_ptr);
    status[2] = 1'b0;
    @(negedge clk);
    chk("tx_en_width", tx_data_en_o, 0);
  endtask

  task automatic hw_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    hw_we = 1'b1;
    hw_addr = a;
    hw_wdata = d;
    if (int'(a) < NREG) m_regs[a] = d;
    @(negedge clk);
    hw_we = 1'b0;
    chk_regs("regs_after_hw");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    #12;
    chk("rst_data_in", data_in_o, 8'hFF);
    chk("rst_tx_en", tx_data_en_o, 0);
    chk("rst_wr", i2c_wr_o, 0);
    chk("rst_wr_addr", i2c_wr_addr_o, 0);
    chk("rst_ptr", ptr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_regs", regs_o, RST_VAL);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // pointer then write
    drv_sta();
    send_rx(8'h03, 0, 8'h00);
    send_rx(8'hA5, 0, 8'h00);
    send_rx(8'h5A, 0, 8'h00);
    drv_sto();
    chk("reg3_lit", regs_o[31:24], 8'hA5);
    chk("reg4_lit", regs_o[39:32], 8'h5A);
    chk("ptr5_lit", ptr_o, 5);

    // repeated-start read from pointer 4
    drv_sta();
    send_rx(8'h04, 0, 8'h00);
    drv_sta();
    repeat (3) read_tx();
    drv_sto();
    chk("ptr7_lit", ptr_o, 7);

    // wrap-around at the last register
    drv_sta();
    send_rx(8'h0B, 0, 8'h00);
    send_rx(8'h11, 0, 8'h00);
    send_rx(8'h22, 0, 8'h00);
    drv_sto();
    chk("reg11_lit", regs_o[95:88], 8'h11);
    chk("reg0_lit", regs_o[7:0], 8'h22);
    chk("ptr1_lit", ptr_o, 1);

    // read-only register
    drv_sta();
    send_rx(8'h02, 0, 8'h00);
    send_rx(8'hEE, 0, 8'h00);
    drv_sto();
    chk("reg2_ro_lit", regs_o[23:16], RST_VAL[23:16]);

    // out-of-range pointer read, pointer persists across stop
    drv_sta();
    send_rx(8'h0D, 0, 8'h00);
    drv_sto();
    drv_sta();
    read_tx();
    drv_sto();
    chk("oor_ptr_wrap", ptr_o, 0);

    // collision: local write wins, pulse still emitted
    drv_sta();
    send_rx(8'h01, 0, 8'h00);
    send_rx(8'h88, 1, 8'h77);
    drv_sto();
    chk("reg1_collide_lit", regs_o[15:8], 8'h77);

    // local write outside the register range is ignored
    hw_write(4'hE, 8'h99);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          drv_sta();
          send_rx(8'($urandom), 0, 8'h00);
          for (int k = 0; k < int'($urandom_range(0, 4)); k++)
            send_rx(8'($urandom), ($urandom_range(0, 4) == 0), 8'($urandom));
          drv_sto();
        end
        1: begin
          drv_sta();
          if ($urandom_range(0, 1) == 1) begin
            send_rx(8'($urandom), 0, 8'h00);
            if ($urandom_range(0, 1) == 1) drv_sto();
            drv_sta();
          end
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) read_tx();
          drv_sto();
        end
        2: hw_write(ADDR_W'($urandom_range(0, 15)), 8'($urandom));
        default: begin
          read_tx();
          send_rx(8'($urandom), 0, 8'h00);
        end
      endcase
    end

    // asynchronous reset in the middle of a read
    drv_sta();
    status[2] = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_data_in", data_in_o, 8'hFF);
    chk("mid_rst_tx_en", tx_data_en_o, 0);
    chk("mid_rst_wr", i2c_wr_o, 0);
    chk("mid_rst_wr_addr", i2c_wr_addr_o, 0);
    chk("mid_rst_ptr", ptr_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_regs", regs_o, RST_VAL);
    status = 8'h00;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    drv_sta();
    read_tx();
    drv_sto();
    repeat (3) @(negedge clk);

    chk("tx_q_drained", exp_tx_q.size(), 0);
    chk("wr_q_drained", exp_wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
